// File: rtl/mips_ctrl_pkg.sv
// Purpose: shared opcodes, FSM state encoding, ALU op codes and datapath mux
//          select encodings for the multi-cycle MIPS control unit.
// Ports:   none (package).
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_R    = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE  = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_SLTI = 6'h0A;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_XORI = 6'h0E;
  localparam logic [OPCODE_W-1:0] OP_LUI  = 6'h0F;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'h2B;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_LW, CLS_SW, CLS_R, CLS_I, CLS_BR, CLS_J, CLS_ILL
  } op_class_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_ITYPE = 3'b011;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_4       = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/opcode_class_decode.sv
// Purpose: combinational opcode classifier for the multi-cycle control unit.
// Ports:   i_opcode  - IR[31:26]
//          o_class   - instruction class (lw/sw/R/I/branch/jump/illegal)
//          o_is_bne  - opcode is bne
//          o_is_jal  - opcode is jal
//          o_is_addi - opcode is addi (ALU add instead of opcode decode)
//          o_legal   - opcode is implemented
module opcode_class_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  output op_class_t           o_class,
  output logic                o_is_bne,
  output logic                o_is_jal,
  output logic                o_is_addi,
  output logic                o_legal
);

  always_comb begin
    o_class   = CLS_ILL;
    o_is_bne  = (i_opcode == OP_BNE);
    o_is_jal  = (i_opcode == OP_JAL);
    o_is_addi = (i_opcode == OP_ADDI);
    case (i_opcode)
      OP_LW:                                   o_class = CLS_LW;
      OP_SW:                                   o_class = CLS_SW;
      OP_R:                                    o_class = CLS_R;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
      OP_XORI, OP_LUI:                         o_class = CLS_I;
      OP_BEQ, OP_BNE:                          o_class = CLS_BR;
      OP_J, OP_JAL:                            o_class = CLS_J;
      default:                                 o_class = CLS_ILL;
    endcase
    o_legal = (o_class != CLS_ILL);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Purpose: Moore FSM sequencing MIPS instructions through fetch/decode/execute/
//          memory/writeback over a shared memory and single ALU.
// Ports:   clk, rst (sync, active-high), opcode (IR[31:26]), mem_ready;
//          datapath controls pc_write, pc_write_cond, pc_write_cond_ne, i_or_d,
//          mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//          alu_src_a, alu_src_b, alu_op, pc_source; illegal_op trap pulse;
//          state_o debug view of the current state.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter bit          HANDSHAKE = 1'b1,
  parameter int unsigned ALU_OP_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_write_cond_ne,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state_o
);

  state_t    r_state, w_next;
  op_class_t w_class, r_class;
  logic      w_is_bne, w_is_jal, w_is_addi, w_legal;
  logic      r_is_bne, r_is_jal, r_is_addi;
  logic      w_ready;

  // Without a handshake the memory always completes in one cycle.
  assign w_ready = HANDSHAKE ? mem_ready : 1'b1;

  opcode_class_decode u_dec (
    .i_opcode  (opcode),
    .o_class   (w_class),
    .o_is_bne  (w_is_bne),
    .o_is_jal  (w_is_jal),
    .o_is_addi (w_is_addi),
    .o_legal   (w_legal)
  );

  // State register; opcode class is captured once in DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_class   <= CLS_ILL;
      r_is_bne  <= 1'b0;
      r_is_jal  <= 1'b0;
      r_is_addi <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_class   <= w_class;
        r_is_bne  <= w_is_bne;
        r_is_jal  <= w_is_jal;
        r_is_addi <= w_is_addi;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (w_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (!w_legal) begin
          w_next = S_ILLEGAL;
        end else begin
          case (w_class)
            CLS_LW, CLS_SW: w_next = S_MEM_ADDR;
            CLS_R:          w_next = S_EXEC_R;
            CLS_I:          w_next = S_EXEC_I;
            CLS_BR:         w_next = S_BRANCH;
            CLS_J:          w_next = S_JUMP;
            default:        w_next = S_ILLEGAL;
          endcase
        end
      end
      S_MEM_ADDR: w_next = (r_class == CLS_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (w_ready) w_next = S_MEM_WB;
      S_MEM_WR:   if (w_ready) w_next = S_FETCH;
      S_EXEC_R:   w_next = S_R_WB;
      S_EXEC_I:   w_next = S_I_WB;
      default:    w_next = S_FETCH;
    endcase
  end

  // Output logic; reset blanks every output so no partial write escapes.
  always_comb begin
    pc_write         = 1'b0;
    pc_write_cond    = 1'b0;
    pc_write_cond_ne = 1'b0;
    i_or_d           = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    reg_dst          = RD_RT;
    mem_to_reg       = M2R_ALU;
    reg_write        = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = SRCB_B;
    alu_op           = ALU_OP_W'(ALU_ADD);
    pc_source        = PCS_ALU;
    illegal_op       = 1'b0;
    state_o          = '0;
    if (!rst) begin
      state_o = STATE_W'(r_state);
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_4;
          ir_write  = w_ready;
          pc_write  = w_ready;
        end
        S_DECODE:   alu_src_b = SRCB_IMM_SH2;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_W'(ALU_RTYPE);
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = RD_RD;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = r_is_addi ? ALU_OP_W'(ALU_ADD) : ALU_OP_W'(ALU_ITYPE);
        end
        S_I_WB:     reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a        = 1'b1;
          alu_op           = ALU_OP_W'(ALU_SUB);
          pc_source        = PCS_ALUOUT;
          pc_write_cond    = !r_is_bne;
          pc_write_cond_ne = r_is_bne;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCS_JUMP;
          if (r_is_jal) begin
            reg_write  = 1'b1;
            reg_dst    = RD_RA;
            mem_to_reg = M2R_PC;
          end
        end
        S_ILLEGAL:  illegal_op = 1'b1;
        default:    ;
      endcase
    end
  end

endmodule
